// File: rtl/flup_protocol_checker_if.sv
// FLU+ link signal bundle. A passive tap uses the monitor modport, which only observes the link.
interface flup_protocol_checker_if #(
  parameter int unsigned DATA_WIDTH    = 512,
  parameter int unsigned HDR_WIDTH     = 128,
  parameter int unsigned CHANNEL_WIDTH = 4,
  parameter int unsigned SOP_POS_WIDTH = 3,
  parameter int unsigned EOP_POS_WIDTH = 6
);
  logic [DATA_WIDTH-1:0]    DATA;
  logic [HDR_WIDTH-1:0]     HEADER;
  logic [CHANNEL_WIDTH-1:0] CHANNEL;
  logic [SOP_POS_WIDTH-1:0] SOP_POS;
  logic [EOP_POS_WIDTH-1:0] EOP_POS;
  logic                     SOP;
  logic                     EOP;
  logic                     SRC_RDY;
  logic                     DST_RDY;

  modport master (
    output DATA, HEADER, CHANNEL, SOP_POS, EOP_POS, SOP, EOP, SRC_RDY,
    input  DST_RDY
  );

  modport slave (
    input  DATA, HEADER, CHANNEL, SOP_POS, EOP_POS, SOP, EOP, SRC_RDY,
    output DST_RDY
  );

  modport monitor (
    input DATA, HEADER, CHANNEL, SOP_POS, EOP_POS, SOP, EOP, SRC_RDY, DST_RDY
  );
endinterface

// File: rtl/flup_protocol_checker.sv
// Passive FLU+ protocol checker: frame/idle tracking, per-frame length check, channel
// consistency, sticky and pulsed error flags, saturating frame and error counters.
module flup_protocol_checker #(
  parameter int unsigned DATA_WIDTH    = 512,
  parameter int unsigned SOP_POS_WIDTH = 3,
  parameter int unsigned EOP_POS_WIDTH = 6,
  parameter int unsigned HDR_WIDTH     = 128,
  parameter int unsigned CHANNEL_WIDTH = 4,
  parameter int unsigned LEN_WIDTH     = 16,
  parameter int unsigned MIN_LEN       = 60,
  parameter int unsigned MAX_LEN       = 16383,
  parameter int unsigned CNT_WIDTH     = 32
) (
  input  logic                     CLK,
  input  logic                     RESET,
  flup_protocol_checker_if.monitor mon,
  input  logic                     ERR_CLEAR,
  output logic                     IN_FRAME,
  output logic [4:0]               ERR_STICKY,
  output logic [4:0]               ERR_PULSE,
  output logic [CNT_WIDTH-1:0]     FRAME_CNT,
  output logic [CNT_WIDTH-1:0]     ERR_CNT
);

  localparam int unsigned BYTES = DATA_WIDTH / 8;
  localparam int unsigned SHIFT = EOP_POS_WIDTH - SOP_POS_WIDTH;

  localparam int ERR_DATA_OUTSIDE = 0;
  localparam int ERR_MISSING_EOP  = 1;
  localparam int ERR_ORPHAN_EOP   = 2;
  localparam int ERR_CHANNEL      = 3;
  localparam int ERR_LENGTH       = 4;

  // Two spare bits keep length sums from wrapping before saturation.
  typedef logic [LEN_WIDTH+1:0] ext_t;

  localparam logic [LEN_WIDTH-1:0] LEN_SAT   = '1;
  localparam ext_t                 LEN_SAT_X = ext_t'(LEN_SAT);
  localparam ext_t                 BYTES_X   = ext_t'(BYTES);
  localparam ext_t                 MIN_X     = ext_t'(MIN_LEN);
  localparam ext_t                 MAX_X     = ext_t'(MAX_LEN);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);

  typedef enum logic {StIdle, StFrame} state_e;

  state_e                   r_state;
  logic [LEN_WIDTH-1:0]     r_len;
  logic [CHANNEL_WIDTH-1:0] r_chan;
  logic [4:0]               r_err_pulse;
  logic [4:0]               r_err_sticky;
  logic [CNT_WIDTH-1:0]     r_frame_cnt;
  logic [CNT_WIDTH-1:0]     r_err_cnt;

  state_e                   w_state_next;
  logic [LEN_WIDTH-1:0]     w_len_next;
  logic [CHANNEL_WIDTH-1:0] w_chan_next;
  logic [4:0]               w_err;
  logic                     w_done;
  logic [LEN_WIDTH-1:0]     w_done_len;

  logic                     w_xfer;
  ext_t                     w_soff;
  ext_t                     w_eop;
  logic                     w_eop_first;
  logic [LEN_WIDTH-1:0]     w_start_len;
  logic [LEN_WIDTH-1:0]     w_single_len;
  logic [LEN_WIDTH-1:0]     w_len_mid;
  logic [LEN_WIDTH-1:0]     w_len_end;
  logic                     w_unused_tap;

  function automatic logic [LEN_WIDTH-1:0] sat_len(input ext_t v);
    return (v > LEN_SAT_X) ? LEN_SAT : v[LEN_WIDTH-1:0];
  endfunction

  // A saturated length is treated as oversize.
  function automatic logic len_bad(input logic [LEN_WIDTH-1:0] len);
    return (ext_t'(len) < MIN_X) || (ext_t'(len) > MAX_X) || (len == LEN_SAT);
  endfunction

  assign w_xfer       = mon.SRC_RDY & mon.DST_RDY;
  assign w_soff       = ext_t'(mon.SOP_POS) << SHIFT;
  assign w_eop        = ext_t'(mon.EOP_POS);
  assign w_eop_first  = mon.SOP & mon.EOP & (w_soff > w_eop);
  assign w_start_len  = sat_len(BYTES_X - w_soff);
  assign w_single_len = sat_len(w_eop - w_soff + ext_t'(1));
  assign w_len_mid    = sat_len(ext_t'(r_len) + BYTES_X);
  assign w_len_end    = sat_len(ext_t'(r_len) + w_eop + ext_t'(1));
  assign w_unused_tap = ^{mon.DATA, mon.HEADER};

  always_comb begin
    w_state_next = r_state;
    w_len_next   = r_len;
    w_chan_next  = r_chan;
    w_err        = '0;
    w_done       = 1'b0;
    w_done_len   = '0;
    if (w_xfer) begin
      // Any SOP word belongs to the frame it opens, so it is never channel-checked.
      if (mon.SOP) begin
        w_chan_next = mon.CHANNEL;
      end
      unique case (r_state)
        StIdle: begin
          if (!mon.SOP) begin
            w_err[ERR_DATA_OUTSIDE] = 1'b1;
          end else if (mon.EOP && !w_eop_first) begin
            w_done     = 1'b1;
            w_done_len = w_single_len;
          end else begin
            w_err[ERR_ORPHAN_EOP] = w_eop_first;
            w_state_next          = StFrame;
            w_len_next            = w_start_len;
          end
        end
        StFrame: begin
          if (!mon.SOP) begin
            w_err[ERR_CHANNEL] = (mon.CHANNEL != r_chan);
            if (mon.EOP) begin
              w_done       = 1'b1;
              w_done_len   = w_len_end;
              w_state_next = StIdle;
            end else begin
              w_len_next = w_len_mid;
            end
          end else if (w_eop_first) begin
            w_done     = 1'b1;
            w_done_len = w_len_end;
            w_len_next = w_start_len;
          end else begin
            // Old frame is dropped without being counted or length-checked.
            w_err[ERR_MISSING_EOP] = 1'b1;
            if (mon.EOP) begin
              w_done       = 1'b1;
              w_done_len   = w_single_len;
              w_state_next = StIdle;
            end else begin
              w_len_next = w_start_len;
            end
          end
        end
        default: w_state_next = StIdle;
      endcase
    end
    w_err[ERR_LENGTH] = w_done & len_bad(w_done_len);
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state      <= StIdle;
      r_len        <= '0;
      r_chan       <= '0;
      r_err_pulse  <= '0;
      r_err_sticky <= '0;
      r_frame_cnt  <= '0;
      r_err_cnt    <= '0;
    end else begin
      r_state     <= w_state_next;
      r_len       <= w_len_next;
      r_chan      <= w_chan_next;
      r_err_pulse <= w_err;
      if (ERR_CLEAR) begin
        // Events in the clearing cycle survive the clear.
        r_err_sticky <= w_err;
        r_frame_cnt  <= w_done ? CNT_ONE : '0;
        r_err_cnt    <= (|w_err) ? CNT_ONE : '0;
      end else begin
        r_err_sticky <= r_err_sticky | w_err;
        if (w_done && (r_frame_cnt != '1)) begin
          r_frame_cnt <= r_frame_cnt + CNT_ONE;
        end
        if ((|w_err) && (r_err_cnt != '1)) begin
          r_err_cnt <= r_err_cnt + CNT_ONE;
        end
      end
    end
  end

  assign IN_FRAME   = (r_state == StFrame);
  assign ERR_STICKY = r_err_sticky;
  assign ERR_PULSE  = r_err_pulse;
  assign FRAME_CNT  = r_frame_cnt;
  assign ERR_CNT    = r_err_cnt;

endmodule

// File: tb/tb_flup_protocol_checker.sv
// Bench for flup_protocol_checker: directed vector table, hand-written long-frame and
// reset sequences, and a randomized stream checked against a frame-level reference model.
module tb_flup_protocol_checker;
  localparam int unsigned DW = 512, HW = 128, CW = 4, SPW = 3, EPW = 6, CNTW = 32;
  localparam longint CMAX = 64'hFFFF_FFFF;

  logic            CLK = 1'b0;
  logic            RESET;
  logic            ERR_CLEAR;
  logic            IN_FRAME;
  logic [4:0]      ERR_STICKY;
  logic [4:0]      ERR_PULSE;
  logic [CNTW-1:0] FRAME_CNT;
  logic [CNTW-1:0] ERR_CNT;

  int n_checks = 0;
  int n_fail   = 0;

  flup_protocol_checker_if #(
    .DATA_WIDTH(DW), .HDR_WIDTH(HW), .CHANNEL_WIDTH(CW),
    .SOP_POS_WIDTH(SPW), .EOP_POS_WIDTH(EPW)
  ) bus ();

  flup_protocol_checker #(
    .DATA_WIDTH(DW), .SOP_POS_WIDTH(SPW), .EOP_POS_WIDTH(EPW), .HDR_WIDTH(HW),
    .CHANNEL_WIDTH(CW), .LEN_WIDTH(16), .MIN_LEN(60), .MAX_LEN(16383), .CNT_WIDTH(CNTW)
  ) dut (
    .CLK(CLK), .RESET(RESET), .mon(bus), .ERR_CLEAR(ERR_CLEAR), .IN_FRAME(IN_FRAME),
    .ERR_STICKY(ERR_STICKY), .ERR_PULSE(ERR_PULSE), .FRAME_CNT(FRAME_CNT), .ERR_CNT(ERR_CNT)
  );

  always #5 CLK = ~CLK;

  // Reference model: frame-level view of the link.
  bit         m_in;
  int         m_len;
  bit [3:0]   m_ch;
  bit [4:0]   m_pulse;
  bit [4:0]   m_sticky;
  longint     m_fcnt;
  longint     m_ecnt;

  function automatic int add_len(int a, int b);
    return (a + b > 65535) ? 65535 : a + b;
  endfunction

  function automatic void model_reset();
    m_in = 0; m_len = 0; m_ch = '0; m_pulse = '0; m_sticky = '0; m_fcnt = 0; m_ecnt = 0;
  endfunction

  function automatic void model_step(bit xfer, bit sop, bit eop, int spos, int epos,
                                     bit [3:0] ch, bit clr);
    bit [4:0] e    = '0;
    int       soff = spos * 8;
    bit       ef   = sop && eop && (soff > epos);
    bit       done = 0;
    int       dlen = 0;
    if (xfer) begin
      if (!m_in) begin
        if (!sop) e[0] = 1;
        else if (eop && !ef) begin done = 1; dlen = epos - soff + 1; end
        else begin e[2] = ef; m_in = 1; m_len = 64 - soff; m_ch = ch; end
      end else if (!sop) begin
        if (ch != m_ch) e[3] = 1;
        if (eop) begin done = 1; dlen = add_len(m_len, epos + 1); m_in = 0; end
        else m_len = add_len(m_len, 64);
      end else if (ef) begin
        done = 1; dlen = add_len(m_len, epos + 1); m_len = 64 - soff; m_ch = ch;
      end else begin
        e[1] = 1;
        if (eop) begin done = 1; dlen = epos - soff + 1; m_in = 0; end
        else begin m_len = 64 - soff; m_ch = ch; end
      end
    end
    if (done && (dlen < 60 || dlen > 16383)) e[4] = 1;
    m_pulse = e;
    if (clr) begin
      m_sticky = e;
      m_fcnt   = done ? 1 : 0;
      m_ecnt   = (e != 0) ? 1 : 0;
    end else begin
      m_sticky = m_sticky | e;
      if (done && m_fcnt < CMAX) m_fcnt++;
      if (e != 0 && m_ecnt < CMAX) m_ecnt++;
    end
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, ".in_frame"}, 64'(IN_FRAME), 64'(m_in));
    check({tag, ".pulse"}, 64'(ERR_PULSE), 64'(m_pulse));
    check({tag, ".sticky"}, 64'(ERR_STICKY), 64'(m_sticky));
    check({tag, ".frame_cnt"}, 64'(FRAME_CNT), 64'(m_fcnt));
    check({tag, ".err_cnt"}, 64'(ERR_CNT), 64'(m_ecnt));
  endtask

  task automatic drive(input bit src, input bit dst, input bit sop, input bit eop,
                       input int spos, input int epos, input bit [3:0] ch, input bit clr);
    bus.SRC_RDY = src;
    bus.DST_RDY = dst;
    bus.SOP     = sop;
    bus.EOP     = eop;
    bus.SOP_POS = 3'(spos);
    bus.EOP_POS = 6'(epos);
    bus.CHANNEL = ch;
    ERR_CLEAR   = clr;
    for (int i = 0; i < DW / 32; i++) bus.DATA[i*32 +: 32] = $urandom();
    for (int i = 0; i < HW / 32; i++) bus.HEADER[i*32 +: 32] = $urandom();
  endtask

  // One clock with model tracking; called and returns at posedge+1.
  task automatic cycle(input bit src, input bit dst, input bit sop, input bit eop,
                       input int spos, input int epos, input bit [3:0] ch, input bit clr,
                       input string tag);
    drive(src, dst, sop, eop, spos, epos, ch, clr);
    @(posedge CLK);
    #1;
    model_step(src && dst, sop, eop, spos, epos, ch, clr);
    check_model(tag);
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    RESET = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    RESET = 1'b0;
    model_reset();
  endtask

  typedef struct {
    bit src, dst, sop, eop;
    int spos, epos;
    bit [3:0] ch;
    bit clr;
    bit x_in;
    bit [4:0] x_pulse, x_sticky;
    int x_fcnt, x_ecnt;
  } vec_t;

  function automatic vec_t mk(bit src, bit dst, bit sop, bit eop, int spos, int epos, int ch,
                              bit clr, bit xi, bit [4:0] xp, bit [4:0] xs, int xf, int xe);
    vec_t v;
    v.src = src; v.dst = dst; v.sop = sop; v.eop = eop; v.spos = spos; v.epos = epos;
    v.ch = 4'(ch); v.clr = clr; v.x_in = xi; v.x_pulse = xp; v.x_sticky = xs;
    v.x_fcnt = xf; v.x_ecnt = xe;
    return v;
  endfunction

  vec_t tbl[$];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bit [3:0] rch;
    // Fields: src dst sop eop spos epos ch clr | in_frame pulse sticky frame_cnt err_cnt
    tbl.push_back(mk(1, 1, 1, 1, 0, 63, 0, 0, 0, 5'b00000, 5'b00000, 1, 0)); // single word
    tbl.push_back(mk(1, 1, 1, 0, 2, 0, 1, 0, 1, 5'b00000, 5'b00000, 1, 0));  // 48 bytes
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 1, 0, 1, 5'b00000, 5'b00000, 1, 0));  // stall x5
    tbl.push_back(mk(1, 0, 1, 1, 0, 63, 9, 0, 1, 5'b00000, 5'b00000, 1, 0));
    tbl.push_back(mk(1, 0, 0, 1, 0, 0, 2, 0, 1, 5'b00000, 5'b00000, 1, 0));
    tbl.push_back(mk(0, 1, 1, 0, 0, 0, 1, 0, 1, 5'b00000, 5'b00000, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 1, 5'b00000, 5'b00000, 1, 0));
    tbl.push_back(mk(1, 1, 0, 0, 0, 0, 1, 0, 1, 5'b00000, 5'b00000, 1, 0));  // +64
    tbl.push_back(mk(1, 1, 0, 1, 0, 9, 1, 0, 0, 5'b00000, 5'b00000, 2, 0));  // 122 bytes
    tbl.push_back(mk(1, 1, 1, 1, 0, 59, 0, 0, 0, 5'b00000, 5'b00000, 3, 0)); // 60 bytes ok
    tbl.push_back(mk(1, 1, 1, 1, 0, 39, 0, 0, 0, 5'b10000, 5'b10000, 4, 1)); // 40 bytes short
    tbl.push_back(mk(0, 1, 1, 1, 0, 0, 0, 0, 0, 5'b00000, 5'b10000, 4, 1));  // pulse drops
    tbl.push_back(mk(1, 1, 1, 1, 4, 5, 2, 0, 1, 5'b00100, 5'b10100, 4, 2));  // orphan EOP
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 5'b00000, 5'b00000, 0, 0));  // clear
    tbl.push_back(mk(1, 1, 1, 0, 0, 0, 2, 0, 1, 5'b00010, 5'b00010, 0, 1));  // missing EOP
    tbl.push_back(mk(1, 1, 0, 1, 0, 63, 2, 0, 0, 5'b00000, 5'b00010, 1, 1)); // 128 bytes
    tbl.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 5'b00001, 5'b00011, 1, 2));  // data outside
    tbl.push_back(mk(1, 1, 0, 1, 0, 63, 0, 0, 0, 5'b00001, 5'b00011, 1, 3)); // EOP only
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 1, 0, 5'b00000, 5'b00000, 0, 0));  // clear
    tbl.push_back(mk(1, 1, 1, 0, 0, 0, 3, 0, 1, 5'b00000, 5'b00000, 0, 0));  // ch 3
    tbl.push_back(mk(1, 1, 0, 0, 0, 0, 5, 0, 1, 5'b01000, 5'b01000, 0, 1));  // ch 5
    tbl.push_back(mk(1, 1, 1, 1, 4, 5, 7, 0, 1, 5'b00000, 5'b01000, 1, 1));  // eop_first ch 7
    tbl.push_back(mk(1, 1, 0, 0, 0, 0, 7, 0, 1, 5'b00000, 5'b01000, 1, 1));
    tbl.push_back(mk(1, 1, 0, 1, 0, 63, 7, 0, 0, 5'b00000, 5'b01000, 2, 1)); // 160 bytes
    tbl.push_back(mk(1, 1, 1, 0, 0, 0, 1, 0, 1, 5'b00000, 5'b01000, 2, 1));
    tbl.push_back(mk(1, 1, 1, 1, 0, 63, 1, 0, 0, 5'b00010, 5'b01010, 3, 2)); // SOP+EOP in frame
    tbl.push_back(mk(1, 1, 1, 1, 0, 9, 0, 1, 0, 5'b10000, 5'b10000, 1, 1));  // clear race
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 5'b00000, 5'b00000, 0, 0));  // clear
    tbl.push_back(mk(1, 1, 1, 0, 7, 0, 0, 0, 1, 5'b00000, 5'b00000, 0, 0));  // 8 bytes
    tbl.push_back(mk(1, 1, 1, 1, 7, 5, 0, 0, 1, 5'b10000, 5'b10000, 1, 1));  // old 14 short
    tbl.push_back(mk(1, 1, 0, 1, 0, 63, 0, 0, 0, 5'b00000, 5'b10000, 2, 1)); // 72 bytes

    ERR_CLEAR = 1'b0;
    do_reset();
    check_model("reset");

    foreach (tbl[i]) begin
      drive(tbl[i].src, tbl[i].dst, tbl[i].sop, tbl[i].eop, tbl[i].spos, tbl[i].epos,
            tbl[i].ch, tbl[i].clr);
      @(posedge CLK);
      #1;
      check($sformatf("vec%0d.in_frame", i), 64'(IN_FRAME), 64'(tbl[i].x_in));
      check($sformatf("vec%0d.pulse", i), 64'(ERR_PULSE), 64'(tbl[i].x_pulse));
      check($sformatf("vec%0d.sticky", i), 64'(ERR_STICKY), 64'(tbl[i].x_sticky));
      check($sformatf("vec%0d.frame_cnt", i), 64'(FRAME_CNT), 64'(tbl[i].x_fcnt));
      check($sformatf("vec%0d.err_cnt", i), 64'(ERR_CNT), 64'(tbl[i].x_ecnt));
    end

    // Length boundaries: 16383 bytes, 16384 bytes, saturated counter, 59 bytes.
    do_reset();
    cycle(1, 1, 1, 0, 0, 0, 1, 0, "max_sop");
    for (int i = 0; i < 254; i++) cycle(1, 1, 0, 0, 0, 0, 1, 0, "max_mid");
    cycle(1, 1, 0, 1, 0, 62, 1, 0, "max_eop");
    check("max_len_ok", 64'(ERR_PULSE), 64'(5'b00000));
    cycle(1, 1, 1, 0, 0, 0, 1, 0, "over_sop");
    for (int i = 0; i < 254; i++) cycle(1, 1, 0, 0, 0, 0, 1, 0, "over_mid");
    cycle(1, 1, 0, 1, 0, 63, 1, 0, "over_eop");
    check("max_len_plus1", 64'(ERR_PULSE), 64'(5'b10000));
    cycle(1, 1, 1, 0, 0, 0, 2, 0, "sat_sop");
    for (int i = 0; i < 1100; i++) cycle(1, 1, 0, 0, 0, 0, 2, 0, "sat_mid");
    cycle(1, 1, 0, 1, 0, 0, 2, 0, "sat_eop");
    check("len_saturated", 64'(ERR_PULSE), 64'(5'b10000));
    cycle(1, 1, 1, 1, 0, 58, 0, 0, "min_minus1");
    check("min_len_minus1", 64'(ERR_PULSE), 64'(5'b10000));
    check("boundary_frames", 64'(FRAME_CNT), 64'(4));

    // Asynchronous reset in the middle of a frame and of a clock period.
    cycle(1, 1, 1, 0, 0, 0, 2, 0, "rst_sop");
    cycle(1, 1, 0, 0, 0, 0, 3, 0, "rst_mid");
    #2;
    RESET = 1'b1;
    #1;
    check("async_rst.in_frame", 64'(IN_FRAME), 64'(0));
    check("async_rst.pulse", 64'(ERR_PULSE), 64'(0));
    check("async_rst.sticky", 64'(ERR_STICKY), 64'(0));
    check("async_rst.frame_cnt", 64'(FRAME_CNT), 64'(0));
    check("async_rst.err_cnt", 64'(ERR_CNT), 64'(0));
    @(posedge CLK);
    #1;
    RESET = 1'b0;
    model_reset();
    cycle(1, 1, 0, 1, 0, 63, 2, 0, "post_rst_eop");
    check("post_rst.pulse", 64'(ERR_PULSE), 64'(5'b00001));
    check("post_rst.frame_cnt", 64'(FRAME_CNT), 64'(0));

    // Randomized stream against the reference model.
    do_reset();
    rch = 4'd0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(15) == 0) rch = 4'($urandom());
      cycle($urandom_range(4) != 0, $urandom_range(4) != 0, $urandom_range(3) == 0,
            $urandom_range(3) == 0, int'($urandom_range(7)), int'($urandom_range(63)),
            rch, $urandom_range(49) == 0, $sformatf("rnd%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/flup_protocol_checker.md
Name: flup_protocol_checker

Overview:
- Synthesizable, passive FrameLink Unaligned Plus (FLU+) protocol checker with per-frame length checking and a per-word channel consistency check.
- Taps any FLU+ link (RX or TX side) and never drives the bus.
- Reports sticky error flags, one-cycle error pulses, and saturating frame/error counters for status registers and hardware debug.

Parameters:
- DATA_WIDTH, 512, data bus width in bits; must be a multiple of 8. BYTES = DATA_WIDTH/8.
- SOP_POS_WIDTH, 3, SOP_POS width.
- EOP_POS_WIDTH, 6, EOP_POS width; must equal log2(BYTES).
- HDR_WIDTH, 128, header width (tapped only, not checked).
- CHANNEL_WIDTH, 4, channel width.
- LEN_WIDTH, 16, frame length counter width in bytes.
- MIN_LEN, 60, minimum legal frame length in bytes.
- MAX_LEN, 16383, maximum legal frame length in bytes.
- CNT_WIDTH, 32, statistics counter width.

Ports:
- CLK  in  1  clock
- RESET  in  1  asynchronous reset, active-high
- DATA  in  DATA_WIDTH  tapped data
- HEADER  in  HDR_WIDTH  tapped header (ignored)
- CHANNEL  in  CHANNEL_WIDTH  tapped channel
- SOP_POS  in  SOP_POS_WIDTH  tapped start position
- EOP_POS  in  EOP_POS_WIDTH  tapped last byte
- SOP  in  1  tapped start of packet
- EOP  in  1  tapped end of packet
- SRC_RDY  in  1  tapped source ready
- DST_RDY  in  1  tapped destination ready
- ERR_CLEAR  in  1  clears sticky flags and counters
- IN_FRAME  out  1  checker is inside a frame
- ERR_STICKY  out  5  sticky error flags
- ERR_PULSE  out  5  per-transfer error flags, 1 cycle
- FRAME_CNT  out  CNT_WIDTH  completed frames
- ERR_CNT  out  CNT_WIDTH  erroneous transfers

Behaviour:
- Interface: one clock, CLK; RESET is asynchronous and active-high.
- Reset: all outputs 0; FSM in IDLE; length counter and latched channel 0.
- Transfer: a cycle with SRC_RDY=1 and DST_RDY=1. All other cycles are ignored and leave state unchanged.
- Definitions:
  - SCALE = 2**(EOP_POS_WIDTH-SOP_POS_WIDTH)
  - soff = SOP_POS*SCALE
  - "eop_first" = SOP && EOP && soff > EOP_POS (the EOP closes the previous frame; the SOP opens a new one)
- Error bits:
  - [0] DATA_OUTSIDE: transfer in IDLE with SOP=0.
  - [1] MISSING_EOP: SOP inside a frame whose EOP is absent.
  - [2] ORPHAN_EOP: eop_first in IDLE.
  - [3] CHANNEL_CHANGE: CHANNEL differs from the latched channel on a transfer that continues the current frame.
  - [4] LENGTH: completed frame length < MIN_LEN or > MAX_LEN.
- FSM IDLE:
  - SOP=0 → err0, stay IDLE. This covers EOP-only transfers as well.
  - SOP only → FRAME; len = BYTES-soff; latch CHANNEL.
  - SOP&EOP, soff<=EOP_POS → complete single-word frame, len = EOP_POS-soff+1; stay IDLE.
  - eop_first → err2; FRAME; len = BYTES-soff; latch CHANNEL.
- FSM FRAME:
  - no SOP, no EOP → len += BYTES; channel check.
  - EOP only → len += EOP_POS+1; channel check; frame complete; go to IDLE.
  - SOP only → err1; the old frame is discarded (not counted, no length check); restart with len = BYTES-soff; latch CHANNEL.
  - eop_first → old frame completes with len += EOP_POS+1; new frame starts, len = BYTES-soff; latch CHANNEL; stay FRAME.
  - SOP&EOP, soff<=EOP_POS → err1; old frame discarded; new single-word frame completes; go to IDLE.
- Channel rules: any word carrying SOP is attributed to the new frame, so no channel check is made on it. The latched channel is updated in the same cycle.
- Frame completion: FRAME_CNT++ and the length check run on every completed frame, including frames that carry other errors.
- Length counter: saturates at 2**LEN_WIDTH-1. A saturated value counts as > MAX_LEN.
- Latency: ERR_PULSE, ERR_STICKY, counters and IN_FRAME are registered and update 1 cycle after the transfer.
- ERR_PULSE behaviour: multiple bits may be set in the same cycle.
- ERR_CNT: increments by 1 per transfer with any error bit set.
- Counters: saturate at all-ones; they never wrap.
- ERR_CLEAR: zeroes ERR_STICKY, FRAME_CNT and ERR_CNT next cycle. FSM and length state are unaffected.
- ERR_CLEAR with a simultaneous error or frame completion: the new event wins. Sticky bits are set to the new error bits and each counter loads 1 if its event occurred that cycle, else 0.
- RESET mid-frame: immediate return to IDLE. The partial frame is neither counted nor flagged.

Test Plan:
Default parameters apply (BYTES=64, SCALE=8).
- Single-word frame: SOP=1, EOP=1, SOP_POS=0, EOP_POS=63 → FRAME_CNT=1, ERR_STICKY=0, IN_FRAME stays 0.
- Three-word frame:
  - Stimulus: SOP_POS=2; middle word stalled 5 cycles by DST_RDY=0; EOP_POS=9.
  - Response: len = 48+64+10 = 122; FRAME_CNT=1, no error.
  - Stalled cycles leave IN_FRAME=1 and len unchanged.
- Short frame plus orphan EOP:
  - Frame of 40 bytes → ERR_PULSE[4]=1 for 1 cycle, ERR_CNT=1.
  - Then, in IDLE, SOP=1, EOP=1, SOP_POS=4, EOP_POS=5 → ERR_STICKY[2] set, IN_FRAME=1.
- Missing EOP and data outside:
  - Inside a frame, SOP=1 with EOP=0 → err1, FRAME_CNT unchanged.
  - Later, in IDLE, a transfer with SOP=0 → err0. Final state ERR_STICKY=5'b00011, ERR_CNT=2.
- Channel change: frame started on CHANNEL=3; middle word carries CHANNEL=5 → ERR_PULSE[3]. An eop_first word with CHANNEL=7 raises no error and latches 7.
- Clear race and reset: ERR_CLEAR asserted in the same cycle as a LENGTH error → ERR_STICKY=5'b10000, ERR_CNT=1, FRAME_CNT=1. Asserting RESET mid-frame → all outputs 0 asynchronously.
